// File: rtl/servant_pm_pkg.sv
// Shared power-management definitions for the servant sleep/wake logic.
//   pm_state_e  : sleep-request FSM states
//   CAUSE_EXT   : wake-cause bit for the external interrupt
//   CAUSE_TIMER : wake-cause bit for the timer match
package servant_pm_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REQ   = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } pm_state_e;

  localparam int unsigned CAUSE_EXT   = 0;
  localparam int unsigned CAUSE_TIMER = 1;

endpackage

// File: rtl/servant_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, clears every stage
//   i_d     : asynchronous input
//   o_q     : input after STAGES flops
module servant_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/servant_sleep_req_gen.sv
// Core-side producer of the sleep/wakeup handshake for the servant clock
// gater. Runs on the free-running clock so it keeps working while wb_clk
// is gated.
//   i_clk          : free-running clock
//   i_rst_n        : asynchronous active-low reset
//   i_wfi          : one-cycle pulse, core executed WFI
//   i_ext_irq      : external interrupt, asynchronous level
//   i_timer_irq    : timer match, synchronous level
//   i_ext_en       : external interrupt wake enable
//   i_timer_en     : timer wake enable
//   i_sleeping     : gater status, high while wb_clk is gated
//   o_sleep_req    : level sleep request to the gater
//   o_wakeup_req   : wakeup request, WAKE_PULSE cycles per wake
//   o_wake_cause   : {timer, ext} cause of the last wake
//   o_sleep_cycles : saturating count of cycles spent in SLEEP
//   o_busy         : high in any state other than RUN
module servant_sleep_req_gen
  import servant_pm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WAKE_PULSE  = 1,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wfi,
  input  logic             i_ext_irq,
  input  logic             i_timer_irq,
  input  logic             i_ext_en,
  input  logic             i_timer_en,
  input  logic             i_sleeping,
  output logic             o_sleep_req,
  output logic             o_wakeup_req,
  output logic [1:0]       o_wake_cause,
  output logic [CNT_W-1:0] o_sleep_cycles,
  output logic             o_busy
);

  localparam logic [7:0] TMO_LAST   = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] PULSE_LAST = 4'(WAKE_PULSE - 1);

  pm_state_e        state_q, state_n;
  logic [7:0]       tmo_q, tmo_n;
  logic [3:0]       pcnt_q, pcnt_n;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       cause_n;
  logic             wreq_n;
  logic             ext_s;
  logic [1:0]       pend_vec;
  logic             pend;

  servant_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_ext_irq),
    .o_q     (ext_s)
  );

  assign pend_vec[CAUSE_EXT]   = ext_s & i_ext_en;
  assign pend_vec[CAUSE_TIMER] = i_timer_irq & i_timer_en;
  assign pend                  = |pend_vec;

  always_comb begin
    state_n = state_q;
    tmo_n   = tmo_q;
    pcnt_n  = pcnt_q;
    cnt_n   = o_sleep_cycles;
    cause_n = o_wake_cause;
    wreq_n  = 1'b0;
    case (state_q)
      RUN: begin
        if (i_wfi && !pend) begin
          state_n = REQ;
          tmo_n   = '0;
          cnt_n   = '0;
        end
      end
      REQ: begin
        if (pend) begin
          state_n = WAKE;
          cause_n = pend_vec;
          wreq_n  = 1'b1;
          pcnt_n  = PULSE_LAST;
        end else if (i_sleeping) begin
          state_n = SLEEP;
        end else if (tmo_q == TMO_LAST) begin
          state_n = RUN;
          cause_n = '0;
        end else begin
          tmo_n = tmo_q + 8'd1;
        end
      end
      SLEEP: begin
        if (o_sleep_cycles != '1) begin
          cnt_n = o_sleep_cycles + CNT_W'(1);
        end
        if (pend) begin
          state_n = WAKE;
          cause_n = pend_vec;
          wreq_n  = 1'b1;
          pcnt_n  = PULSE_LAST;
        end else if (!i_sleeping) begin
          // gater released the clock without a wake source: fault
          state_n = RUN;
          cause_n = '0;
        end
      end
      WAKE: begin
        if (o_wakeup_req && (pcnt_q != '0)) begin
          wreq_n = 1'b1;
          pcnt_n = pcnt_q - 4'd1;
        end
        // exit on the same edge that ends the pulse, once the gater is awake
        if (!wreq_n && !i_sleeping) begin
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= RUN;
      tmo_q          <= '0;
      pcnt_q         <= '0;
      o_sleep_req    <= 1'b0;
      o_wakeup_req   <= 1'b0;
      o_wake_cause   <= '0;
      o_sleep_cycles <= '0;
      o_busy         <= 1'b0;
    end else begin
      state_q        <= state_n;
      tmo_q          <= tmo_n;
      pcnt_q         <= pcnt_n;
      o_sleep_req    <= (state_n == REQ) || (state_n == SLEEP);
      o_wakeup_req   <= wreq_n;
      o_wake_cause   <= cause_n;
      o_sleep_cycles <= cnt_n;
      o_busy         <= (state_n != RUN);
    end
  end

endmodule

// File: tb/tb_servant_sleep_req_gen.sv
module tb_servant_sleep_req_gen;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_wfi;
  logic        i_ext_irq;
  logic        i_timer_irq;
  logic        i_ext_en;
  logic        i_timer_en;
  logic        i_sleeping;

  logic        o_sleep_req;
  logic        o_wakeup_req;
  logic [1:0]  o_wake_cause;
  logic [15:0] o_sleep_cycles;
  logic        o_busy;

  logic        s4_sleep_req;
  logic        s4_wakeup_req;
  logic [1:0]  s4_wake_cause;
  logic [3:0]  s4_sleep_cycles;
  logic        s4_busy;

  int n_vec;
  int n_bad;

  servant_sleep_req_gen #(
    .SYNC_STAGES (2),
    .WAKE_PULSE  (1),
    .ACK_TIMEOUT (8),
    .CNT_W       (16)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_wfi          (i_wfi),
    .i_ext_irq      (i_ext_irq),
    .i_timer_irq    (i_timer_irq),
    .i_ext_en       (i_ext_en),
    .i_timer_en     (i_timer_en),
    .i_sleeping     (i_sleeping),
    .o_sleep_req    (o_sleep_req),
    .o_wakeup_req   (o_wakeup_req),
    .o_wake_cause   (o_wake_cause),
    .o_sleep_cycles (o_sleep_cycles),
    .o_busy         (o_busy)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  servant_sleep_req_gen #(
    .SYNC_STAGES (2),
    .WAKE_PULSE  (1),
    .ACK_TIMEOUT (8),
    .CNT_W       (4)
  ) dut4 (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_wfi          (i_wfi),
    .i_ext_irq      (i_ext_irq),
    .i_timer_irq    (i_timer_irq),
    .i_ext_en       (i_ext_en),
    .i_timer_en     (i_timer_en),
    .i_sleeping     (i_sleeping),
    .o_sleep_req    (s4_sleep_req),
    .o_wakeup_req   (s4_wakeup_req),
    .o_wake_cause   (s4_wake_cause),
    .o_sleep_cycles (s4_sleep_cycles),
    .o_busy         (s4_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       wfi;
    logic       ext;
    logic       tmr;
    logic       ext_en;
    logic       tmr_en;
    logic       slp;
    logic       sreq;
    logic       wreq;
    logic [1:0] cause;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge. The two request
  // outputs must never overlap.
  task automatic step();
    @(posedge i_clk);
    #1;
    if (o_sleep_req && o_wakeup_req) begin
      n_bad++;
      $display("FAIL req_overlap: sleep_req=%b wakeup_req=%b want not both", o_sleep_req, o_wakeup_req);
    end
  endtask

  task automatic set_in(input logic wfi, input logic ext, input logic tmr,
                        input logic ext_en, input logic tmr_en, input logic slp);
    i_wfi       = wfi;
    i_ext_irq   = ext;
    i_timer_irq = tmr;
    i_ext_en    = ext_en;
    i_timer_en  = tmr_en;
    i_sleeping  = slp;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    i_rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);

    // inputs: wfi ext tmr ext_en tmr_en slp | expected: sreq wreq cause busy
    // Simultaneous sources in SLEEP; ext alone with ext_en=0 must not wake.
    vq.push_back('{1,0,0,1,1,0, 1,0,2'd0,1});
    vq.push_back('{0,0,0,1,1,1, 1,0,2'd0,1});
    vq.push_back('{0,1,0,0,1,1, 1,0,2'd0,1});
    vq.push_back('{0,1,0,0,1,1, 1,0,2'd0,1});
    vq.push_back('{0,1,0,0,1,1, 1,0,2'd0,1});
    vq.push_back('{0,1,1,1,1,1, 0,1,2'd3,1});
    vq.push_back('{0,0,0,0,0,1, 0,0,2'd3,1});
    vq.push_back('{0,0,0,0,0,0, 0,0,2'd3,0});
    // WFI with a synced, enabled ext irq pending: NOP, cause untouched.
    vq.push_back('{0,1,0,1,0,0, 0,0,2'd3,0});
    vq.push_back('{0,1,0,1,0,0, 0,0,2'd3,0});
    vq.push_back('{1,1,0,1,0,0, 0,0,2'd3,0});
    vq.push_back('{0,0,0,1,0,0, 0,0,2'd3,0});
    vq.push_back('{0,0,0,1,0,0, 0,0,2'd3,0});
    vq.push_back('{0,0,0,1,0,0, 0,0,2'd3,0});
    // Gater never acks: sleep_req high 8 cycles, then RUN with cause 0.
    // The WFI in the fourth REQ cycle is ignored.
    vq.push_back('{1,0,0,1,0,0, 1,0,2'd3,1});
    vq.push_back('{0,0,0,1,0,0, 1,0,2'd3,1});
    vq.push_back('{0,0,0,1,0,0, 1,0,2'd3,1});
    vq.push_back('{1,0,0,1,0,0, 1,0,2'd3,1});
    vq.push_back('{0,0,0,1,0,0, 1,0,2'd3,1});
    vq.push_back('{0,0,0,1,0,0, 1,0,2'd3,1});
    vq.push_back('{0,0,0,1,0,0, 1,0,2'd3,1});
    vq.push_back('{0,0,0,1,0,0, 1,0,2'd3,1});
    vq.push_back('{0,0,0,1,0,0, 0,0,2'd0,0});

    #1;
    chk("reset_outputs", {o_sleep_req, o_wakeup_req, o_wake_cause, o_sleep_cycles, o_busy}, 32'd0);
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;

    foreach (vq[i]) begin
      set_in(vq[i].wfi, vq[i].ext, vq[i].tmr, vq[i].ext_en, vq[i].tmr_en, vq[i].slp);
      step();
      n_vec++;
      if ({o_sleep_req, o_wakeup_req, o_wake_cause, o_busy} !==
          {vq[i].sreq, vq[i].wreq, vq[i].cause, vq[i].busy}) begin
        n_bad++;
        $display("FAIL vec%0d sreq/wreq/cause/busy: got %b want %b", i,
                 {o_sleep_req, o_wakeup_req, o_wake_cause, o_busy},
                 {vq[i].sreq, vq[i].wreq, vq[i].cause, vq[i].busy});
      end
    end

    // WFI + ack two cycles later, timer wake after 100 cycles in SLEEP.
    set_in(1, 0, 0, 0, 1, 0);
    step();
    chk("t1_sreq_wfi1", {31'd0, o_sleep_req}, 32'd1);
    set_in(0, 0, 0, 0, 1, 0);
    step();
    chk("t1_sreq_req2", {31'd0, o_sleep_req}, 32'd1);
    set_in(0, 0, 0, 0, 1, 1);
    step();
    chk("t1_sleep_entry", {o_sleep_req, o_busy, o_sleep_cycles}, {16'd0, 1'b1, 1'b1, 16'd0});
    repeat (100) step();
    set_in(0, 0, 1, 0, 1, 1);
    step();
    // 100 idle SLEEP cycles plus the cycle the timer is seen in
    chk("t1_wake", {o_sleep_req, o_wakeup_req, o_wake_cause, o_busy}, 32'b0_1_10_1);
    chk("t1_cycles", {16'd0, o_sleep_cycles}, 32'd101);
    chk("sat_cycles_101", {28'd0, s4_sleep_cycles}, 32'd15);
    set_in(0, 0, 0, 0, 1, 1);
    step();
    chk("t1_pulse_end", {o_wakeup_req, o_busy}, 32'b01);
    set_in(0, 0, 0, 0, 1, 0);
    step();
    chk("t1_run", {o_sleep_req, o_wakeup_req, o_busy, o_wake_cause}, 32'b0_0_0_10);
    chk("t1_cycles_held", {16'd0, o_sleep_cycles}, 32'd101);

    // Gater drops i_sleeping with no wake source after 40 SLEEP cycles.
    set_in(1, 0, 0, 0, 1, 0);
    step();
    chk("t2_cycles_clr", {15'd0, o_sleep_req, o_sleep_cycles}, {15'd0, 1'b1, 16'd0});
    set_in(0, 0, 0, 0, 1, 1);
    step();
    repeat (39) step();
    set_in(0, 0, 0, 0, 1, 0);
    step();
    chk("t2_fault_run", {o_sleep_req, o_wakeup_req, o_busy, o_wake_cause}, 32'd0);
    chk("t2_cycles", {16'd0, o_sleep_cycles}, 32'd40);
    chk("sat_cycles_40", {28'd0, s4_sleep_cycles}, 32'd15);

    // Asynchronous reset between edges in SLEEP, then a normal episode.
    set_in(1, 0, 0, 0, 1, 0);
    step();
    set_in(0, 0, 0, 0, 1, 1);
    step();
    repeat (5) step();
    #3 i_rst_n = 1'b0;
    #1;
    chk("rst_async", {o_sleep_req, o_wakeup_req, o_busy, o_wake_cause, o_sleep_cycles}, 32'd0);
    chk("rst_async_s4", {28'd0, s4_sleep_req, s4_busy, s4_sleep_cycles == 4'd0}, 32'd1);
    #2;
    set_in(0, 0, 0, 0, 1, 0);
    i_rst_n = 1'b1;
    step();
    chk("rst_idle", {o_sleep_req, o_busy}, 32'd0);
    set_in(1, 0, 0, 0, 1, 0);
    step();
    chk("rst_wfi", {o_sleep_req, o_busy}, 32'b11);
    set_in(0, 0, 0, 0, 1, 1);
    step();
    set_in(0, 0, 1, 0, 1, 1);
    step();
    chk("rst_wake", {o_sleep_req, o_wakeup_req, o_wake_cause}, 32'b0_1_10);
    set_in(0, 0, 0, 0, 1, 0);
    step();
    chk("rst_run", {o_sleep_req, o_wakeup_req, o_busy, o_sleep_cycles}, {13'd0, 3'b000, 16'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
